// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream filter: FSM state encoding,
// pixel width, default frame geometry and frame-size/address helpers.
package pixel_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOADED,
        PROC,
        EMIT,
        DONE
    } state_t;

    localparam int unsigned PIXEL_DEPTH    = 8;
    localparam int unsigned DEFAULT_WIDTH  = 410;
    localparam int unsigned DEFAULT_HEIGHT = 361;

    function automatic int unsigned frame_size(input int unsigned width, input int unsigned height);
        return width * height;
    endfunction

    // Counter width for n entries; never below one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEFAULT_N = frame_size(DEFAULT_WIDTH, DEFAULT_HEIGHT);

endpackage

// File: rtl/pixel_stream_filter_if.sv
// Pixel-stream handshake bundle between the image host (master) and the
// filter device (slave).
interface pixel_stream_filter_if
    import pixel_stream_pkg::*;
#(
    parameter int unsigned DEPTH = PIXEL_DEPTH
);
    logic [DEPTH-1:0] image_input;
    logic             enable;
    logic             enable_process;
    logic [DEPTH-1:0] image_output;
    logic             finish;
    logic             busy;

    modport master (
        output image_input, enable, enable_process,
        input  image_output, finish, busy
    );

    modport slave (
        input  image_input, enable, enable_process,
        output image_output, finish, busy
    );
endinterface

// File: rtl/hsmooth_window.sv
// Horizontal [1 2 1]/4 smoothing window over a raster-order pixel stream.
// Row edges are replicated; the right-edge pixel of each row is produced one
// cycle after it arrives, in the slot left free by the next row's first pixel.
module hsmooth_window
    import pixel_stream_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH     = PIXEL_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DEPTH-1:0] in_pix,
    output logic             out_valid,
    output logic [DEPTH-1:0] out_pix
);
    localparam int unsigned     CW       = addr_width(IMG_WIDTH);
    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_WIDTH - 1);

    logic [DEPTH-1:0] prev;
    logic [DEPTH-1:0] cur;
    logic [CW-1:0]    col;
    logic             tail;

    // Rounded (l + 2c + r + 2) >> 2 at DEPTH+2 bits; the quotient fits DEPTH.
    function automatic logic [DEPTH-1:0] smooth(input logic [DEPTH-1:0] l,
                                                input logic [DEPTH-1:0] c,
                                                input logic [DEPTH-1:0] r);
        logic [DEPTH+1:0] sum;
        sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + (DEPTH+2)'(2);
        return sum[DEPTH+1:2];
    endfunction

    // Shift window, column tracking and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            cur       <= '0;
            col       <= '0;
            tail      <= 1'b0;
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else begin
            out_valid <= 1'b0;
            tail      <= in_valid && (col == COL_LAST);
            if (in_valid && (col != '0)) begin
                out_valid <= 1'b1;
                out_pix   <= smooth(prev, cur, in_pix);
            end else if (tail) begin
                out_valid <= 1'b1;
                out_pix   <= smooth(prev, cur, cur);
            end
            if (in_valid) begin
                prev <= (col == '0) ? in_pix : cur;
                cur  <= in_pix;
                col  <= (col == COL_LAST) ? '0 : col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pixel_stream_filter.sv
// Pixel stream filter: loads a frame, smooths it horizontally, streams it
// back under finish. Optional binarisation with macro PIXEL_THRESHOLD_EN.
module pixel_stream_filter
    import pixel_stream_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEFAULT_HEIGHT,
    parameter int unsigned DEPTH      = PIXEL_DEPTH,
    parameter int unsigned THRESH     = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    pixel_stream_filter_if.slave  bus
);
    localparam int unsigned   N    = frame_size(IMG_WIDTH, IMG_HEIGHT);
    localparam int unsigned   AW   = addr_width(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t           state;
    state_t           next_state;
    logic [AW-1:0]    wr;
    logic [AW-1:0]    rd;
    logic             rd_run;
    logic [DEPTH-1:0] in_mem  [N];
    logic [DEPTH-1:0] out_mem [N];
    logic [DEPTH-1:0] mem_data;
    logic             mem_valid;
    logic             win_valid;
    logic [DEPTH-1:0] win_pix;
    logic [DEPTH-1:0] wdata;
    logic             in_we;
    logic [AW-1:0]    in_waddr;
    logic             out_we;
    logic             emit;
    logic             busy_d;

    hsmooth_window #(
        .IMG_WIDTH (IMG_WIDTH),
        .DEPTH     (DEPTH)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mem_valid),
        .in_pix    (mem_data),
        .out_valid (win_valid),
        .out_pix   (win_pix)
    );

    // Value written to the output frame.
    always_comb begin
`ifdef PIXEL_THRESHOLD_EN
        wdata = (int'(win_pix) >= int'(THRESH)) ? '1 : '0;
`else
        wdata = win_pix;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.enable)                   next_state = LOAD;
            LOAD:    if (bus.enable && wr == LAST)     next_state = LOADED;
            LOADED:  if (bus.enable_process)           next_state = PROC;
            PROC:    if (win_valid && wr == LAST)      next_state = EMIT;
            EMIT:    if (rd == LAST)                   next_state = DONE;
            DONE:    if (!bus.enable)                  next_state = IDLE;
            default:                                   next_state = IDLE;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        in_we    = ((state == IDLE) || (state == LOAD)) && bus.enable;
        in_waddr = (state == IDLE) ? '0 : wr;
        out_we   = (state == PROC) && win_valid;
        emit     = (state == EMIT);
        busy_d   = (next_state == LOAD) || (next_state == PROC) || (next_state == EMIT);
    end

    // Write/read counters; wr is reused for out_mem writes during PROC,
    // rd for in_mem reads during PROC and out_mem reads during EMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr        <= '0;
            rd        <= '0;
            rd_run    <= 1'b0;
            mem_valid <= 1'b0;
        end else begin
            mem_valid <= (state == PROC) && rd_run;
            case (state)
                IDLE: begin
                    wr <= bus.enable ? AW'(1) : '0;
                    rd <= '0;
                end
                LOAD: begin
                    if (bus.enable && wr != LAST) wr <= wr + 1'b1;
                end
                LOADED: begin
                    if (bus.enable_process) begin
                        wr     <= '0;
                        rd     <= '0;
                        rd_run <= 1'b1;
                    end
                end
                PROC: begin
                    if (rd_run) begin
                        if (rd == LAST) rd_run <= 1'b0;
                        else            rd     <= rd + 1'b1;
                    end
                    if (win_valid) begin
                        if (wr != LAST) wr <= wr + 1'b1;
                        else            rd <= '0;
                    end
                end
                EMIT: begin
                    if (rd != LAST) rd <= rd + 1'b1;
                end
                default: begin
                    wr <= '0;
                    rd <= '0;
                end
            endcase
        end
    end

    // Frame memories and the synchronous in_mem read port.
    always_ff @(posedge clk) begin
        if (in_we)  in_mem[in_waddr] <= bus.image_input;
        if (out_we) out_mem[wr]      <= wdata;
        mem_data <= in_mem[rd];
    end

    // Registered output stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.finish       <= 1'b0;
            bus.image_output <= '0;
            bus.busy         <= 1'b0;
        end else begin
            bus.busy         <= busy_d;
            bus.finish       <= emit;
            bus.image_output <= emit ? out_mem[rd] : '0;
        end
    end
endmodule

// File: tb/tb_pixel_stream_filter.sv
// Scoreboard bench for pixel_stream_filter on a 4x2 frame.
module tb_pixel_stream_filter;
    import pixel_stream_pkg::*;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int N    = W * H;
    localparam int D    = PIXEL_DEPTH;
    localparam int TH   = 128;
    localparam int PMAX = (1 << D) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_stream_filter_if #(.DEPTH(D)) bus ();

    pixel_stream_filter #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DEPTH      (D),
        .THRESH     (TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int frame [N];
    int exp_q [$];
    int run_len = 0;
    int frames_done = 0;
    bit prev_finish = 1'b0;
    bit aborting = 1'b0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: [1 2 1]/4 with rounding, edges replicated within the row.
    function automatic int ref_pixel(input int r, input int c);
        int l, m, rr, v;
        l  = frame[r * W + ((c == 0) ? 0 : c - 1)];
        m  = frame[r * W + c];
        rr = frame[r * W + ((c == W - 1) ? c : c + 1)];
        v  = (l + 2 * m + rr + 2) / 4;
`ifdef PIXEL_THRESHOLD_EN
        v  = (v >= TH) ? PMAX : 0;
`endif
        return v;
    endfunction

    // Monitor: compares every streamed pixel against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.finish) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_unexpected: actual %0d required no output", bus.image_output);
                end else begin
                    check("pixel", int'(bus.image_output), exp_q.pop_front());
                end
                run_len++;
            end else begin
                check("output_zero_when_idle", int'(bus.image_output), 0);
                if (prev_finish) begin
                    if (!aborting) begin
                        check("finish_run_length", run_len, N);
                        frames_done++;
                    end
                    run_len = 0;
                end
            end
            prev_finish = bus.finish;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.enable      = 1'b0;
            bus.image_input = D'($urandom);
        end
    endtask

    task automatic run_frame(input bit proc_early, input int stall_at, input bit rand_stall,
                             input bit extra, input int abort_after);
        int cnt;
        int start;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(ref_pixel(r, c));
        bus.enable_process = proc_early;
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) idle_cycles(3);
            else if (rand_stall && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
            @(negedge clk);
            bus.enable      = 1'b1;
            bus.image_input = D'(frame[i]);
            if (i == 1) check("busy_in_load", int'(bus.busy), 1);
        end
        @(negedge clk);
        if (extra) begin
            bus.enable      = 1'b1;
            bus.image_input = D'($urandom);
            @(negedge clk);
        end
        bus.enable = 1'b0;
        cnt = 0;
        if (!proc_early) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.enable_process = 1'b1;
            do begin
                @(negedge clk);
                cnt++;
            end while (!bus.finish && cnt < 4 * N + 50);
            check("proc_latency_within_bound", int'(cnt <= N + 5), 1);
        end else begin
            do begin
                @(negedge clk);
                cnt++;
            end while (!bus.finish && cnt < 4 * N + 50);
            check("first_output_seen", int'(bus.finish), 1);
        end
        if (abort_after >= 0) begin
            repeat (abort_after) @(negedge clk);
            aborting           = 1'b1;
            rst                = 1'b1;
            bus.enable_process = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            check("abort_finish", int'(bus.finish), 0);
            check("abort_image_output", int'(bus.image_output), 0);
            check("abort_busy", int'(bus.busy), 0);
            @(negedge clk);
            exp_q.delete();
            aborting = 1'b0;
        end else begin
            start = frames_done;
            cnt   = 0;
            while (frames_done == start && cnt < 4 * N + 50) begin
                @(negedge clk);
                cnt++;
            end
            check("frame_completed", int'(frames_done != start), 1);
            bus.enable_process = 1'b0;
            check("busy_after_frame", int'(bus.busy), 0);
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) frame[i] = ($urandom_range(0, 1) == 1) ? PMAX : 0;
            else                           frame[i] = $urandom_range(0, PMAX);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable         = 1'b0;
        bus.enable_process = 1'b0;
        bus.image_input    = '0;
        repeat (3) @(negedge clk);
        check("reset_finish", int'(bus.finish), 0);
        check("reset_image_output", int'(bus.image_output), 0);
        check("reset_busy", int'(bus.busy), 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Two rows with distinct content: edges replicate, no cross-row mixing.
        frame = '{10, 20, 30, 40, 200, 200, 200, 200};
        run_frame(1'b0, -1, 1'b0, 1'b0, -1);
        // Same frame with a 3-cycle load stall after pixel 2 and a surplus pixel.
        run_frame(1'b0, 2, 1'b0, 1'b1, -1);
        // Start request held from the first load cycle.
        run_frame(1'b1, -1, 1'b0, 1'b0, -1);
        // Reset two cycles into the output stream, then reload.
        random_frame();
        run_frame(1'b0, -1, 1'b0, 1'b0, 2);
        frame = '{0, 255, 0, 255, 0, 0, 0, 0};
        for (int i = W; i < N; i++) frame[i] = $urandom_range(0, PMAX);
        run_frame(1'b0, -1, 1'b0, 1'b0, -1);
        frame = '{50, 100, 150, 250, 0, 0, 0, 0};
        for (int i = W; i < N; i++) frame[i] = $urandom_range(0, PMAX);
        run_frame(1'b0, -1, 1'b0, 1'b0, -1);
        // Randomised frames with random stalls, surplus pixels and start timing.
        for (int f = 0; f < 10; f++) begin
            random_frame();
            run_frame(1'($urandom_range(0, 1)), -1, 1'b1, 1'($urandom_range(0, 1)), -1);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
